// File: rtl/adpll_pkg.sv
// Shared definitions for the all-digital PLL blocks: mode encodings,
// modulus limits and the modulus-exponent clamp.
package adpll_pkg;

  localparam logic MODE_UPDOWN = 1'b0;
  localparam logic MODE_DUAL   = 1'b1;

  localparam int K_MIN = 3;

  // Clamp a requested modulus exponent into [K_MIN, width].
  function automatic int k_clamp(input int k_sel, input int width);
    int k;
    k = k_sel;
    if (k < K_MIN) k = K_MIN;
    if (k > width) k = width;
    return k;
  endfunction

endpackage

// File: rtl/k_mod_decode.sv
// Decodes the effective modulus exponent into the terminal thresholds
// M-1, M/2-1 and -M/2 (two's complement), all WIDTH bits wide.
module k_mod_decode
  import adpll_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic [KW-1:0]    k_eff,
  output logic [WIDTH-1:0] thr_full,
  output logic [WIDTH-1:0] thr_half_pos,
  output logic [WIDTH-1:0] thr_half_neg
);

  // M-1 is k ones, M/2-1 is k-1 ones, and -M/2 is the bitwise inverse of M/2-1.
  always_comb begin
    thr_full     = '0;
    thr_half_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      thr_full[i]     = (i < int'(k_eff));
      thr_half_pos[i] = (i < int'(k_eff) - 1);
    end
    thr_half_neg = ~thr_half_pos;
  end

endmodule

// File: rtl/k_counter_filter.sv
// K-counter loop filter: integrates the phase-detector sign and emits
// registered one-cycle carry/borrow pulses toward the DCO.
module k_counter_filter
  import adpll_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dn_up,
  input  logic [KW-1:0]    k_sel,
  input  logic             mode,
  output logic             carry,
  output logic             borrow,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_dn
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_dn_q, count_dn_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             mode_q, mode_d;

  logic [KW-1:0]    k_eff;
  logic [WIDTH-1:0] thr_full;
  logic [WIDTH-1:0] thr_half_pos;
  logic [WIDTH-1:0] thr_half_neg;

  always_comb begin
    k_eff = KW'(k_clamp(int'(k_sel), WIDTH));
  end

  k_mod_decode #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_decode (
    .k_eff        (k_eff),
    .thr_full     (thr_full),
    .thr_half_pos (thr_half_pos),
    .thr_half_neg (thr_half_neg)
  );

  // Terminal tests use >= / <= so a count stranded above a shrunken modulus
  // wraps on its next step in that direction instead of running on.
  always_comb begin
    count_d    = count_q;
    count_dn_d = count_dn_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    mode_d     = mode;
    if (mode != mode_q) begin
      count_d    = '0;
      count_dn_d = '0;
    end else if (en) begin
      if (mode_q == MODE_DUAL) begin
        if (!dn_up) begin
          if (count_q >= thr_full) begin
            count_d = '0;
            carry_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_dn_q >= thr_full) begin
            count_dn_d = '0;
            borrow_d   = 1'b1;
          end else begin
            count_dn_d = count_dn_q + WIDTH'(1);
          end
        end
      end else begin
        if (!dn_up) begin
          if ($signed(count_q) >= $signed(thr_half_pos)) begin
            count_d = '0;
            carry_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if ($signed(count_q) <= $signed(thr_half_neg)) begin
            count_d  = '0;
            borrow_d = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      count_dn_q <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      mode_q     <= MODE_UPDOWN;
    end else begin
      count_q    <= count_d;
      count_dn_q <= count_dn_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      mode_q     <= mode_d;
    end
  end

  assign count    = count_q;
  assign count_dn = count_dn_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;

endmodule

// File: tb/tb_k_counter_filter.sv
// Directed bench for k_counter_filter with hand-computed expectations.
module tb_k_counter_filter;

  localparam int WIDTH = 8;
  localparam int KW    = $clog2(WIDTH) + 1;

  logic             clk;
  logic             reset;
  logic             en;
  logic             dn_up;
  logic [KW-1:0]    k_sel;
  logic             mode;
  logic             carry;
  logic             borrow;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_dn;

  int checks;
  int errors;

  k_counter_filter #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dn_up    (dn_up),
    .k_sel    (k_sel),
    .mode     (mode),
    .carry    (carry),
    .borrow   (borrow),
    .count    (count),
    .count_dn (count_dn)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input int cd, input int cy, input int bw);
    check({tag, ".count"},    32'(count),    32'(c & 8'hFF));
    check({tag, ".count_dn"}, 32'(count_dn), 32'(cd & 8'hFF));
    check({tag, ".carry"},    32'(carry),    32'(cy));
    check({tag, ".borrow"},   32'(borrow),   32'(bw));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    en     = 1'b0;
    dn_up  = 1'b0;
    k_sel  = KW'(3);
    mode   = 1'b1;
    step();
    step();
    check_all("rst_held", 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check_all("rst_rel0", 0, 0, 0, 0);
    step();
    check_all("rst_rel1", 0, 0, 0, 0);

    // mode 1, M=8, up steps
    en = 1'b1;
    dn_up = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_all($sformatf("m1_up%0d", i), i % 8, 0, (i % 8 == 0) ? 1 : 0, 0);
    end

    // mode 1, M=8, down steps
    dn_up = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_all($sformatf("m1_dn%0d", i), 0, i % 8, 0, (i == 8) ? 1 : 0);
    end

    // build count=5, count_dn=3 then switch to mode 0
    dn_up = 1'b0;
    for (int i = 0; i < 5; i++) step();
    dn_up = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_all("pre_sw", 5, 3, 0, 0);
    mode = 1'b0;
    dn_up = 1'b0;
    step();
    check_all("sw_clr", 0, 0, 0, 0);
    step();
    check_all("sw_up1", 1, 0, 0, 0);
    dn_up = 1'b1;
    step();
    check_all("sw_dn0", 0, 0, 0, 0);

    // mode 0, M=16
    k_sel = KW'(4);
    dn_up = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_all($sformatf("m0_up%0d", i), (i == 8) ? 0 : i, 0, (i == 8) ? 1 : 0, 0);
    end
    dn_up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check_all($sformatf("m0_dn%0d", i), (i == 9) ? 0 : -i, 0, 0, (i == 9) ? 1 : 0);
    end

    // enable gating
    dn_up = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_all("en_pre", 4, 0, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all($sformatf("en_off%0d", i), 4, 0, 0, 0);
    end
    en = 1'b1;

    // k_sel=0 clamps to M=8: count 4 is beyond +3, so next up step wraps
    k_sel = KW'(0);
    step();
    check_all("kclamp_lo_wrap", 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_all($sformatf("kclamp_lo%0d", i), (i == 4) ? 0 : i, 0, (i == 4) ? 1 : 0, 0);
    end

    // k_sel=15 clamps to M=256 in mode 1
    k_sel = KW'(15);
    mode = 1'b1;
    step();
    check_all("sw_m1", 0, 0, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      step();
      check_all($sformatf("kclamp_hi%0d", i), i % 256, 0, (i == 256) ? 1 : 0, 0);
    end

    // asynchronous reset mid-cycle with count=5
    for (int i = 0; i < 5; i++) step();
    check_all("arst_pre", 5, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("arst_now", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    en = 1'b0;
    step();
    check_all("arst_rel", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
